// File: rtl/boot_rom_arbiter_if.sv
// Bus bundle between the core's instr/data ports, the boot ROM arbiter and the ROM wrapper.
// master = core + ROM wrapper side, slave = arbiter side.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif

interface boot_rom_arbiter_if #(
    parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
);
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [DATA_WIDTH-1:0] instr_rdata_o;

    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;
    logic                  data_err_o;

    logic                  rom_en_o;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0] rom_rdata_i;

    modport master (
        output instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, rom_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  rom_en_o, rom_addr_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, rom_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output rom_en_o, rom_addr_o
    );
endinterface

// File: rtl/boot_rom_arbiter.sv
// Shares the single-ported boot ROM between instruction fetch and data ports.
// Combinational grant, one-cycle response pipeline matching the ROM read latency.
module boot_rom_arbiter #(
    parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input logic               clk,
    input logic               rst_n,
    boot_rom_arbiter_if.slave bus
);
    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e r_owner;
    port_e r_last;
    logic  r_rvalid;
    logic  r_err;

    port_e w_winner;
    logic  w_gnt_instr;
    logic  w_gnt_data;
    logic  w_any_gnt;
    logic  w_instr_valid;
    logic  w_data_valid;

    // NOTE: both grants get a default before the branches so no latch is inferred.
    always_comb begin
        w_gnt_instr = 1'b0;
        w_gnt_data  = 1'b0;
        if (bus.instr_req_i && bus.data_req_i) begin
            if (ARB_MODE == 1 || r_last == PORT_DATA) w_gnt_instr = 1'b1;
            else                                      w_gnt_data  = 1'b1;
        end else begin
            w_gnt_instr = bus.instr_req_i;
            w_gnt_data  = bus.data_req_i;
        end
    end

    assign w_any_gnt = w_gnt_instr | w_gnt_data;
    assign w_winner  = w_gnt_data ? PORT_DATA : PORT_INSTR;

    assign bus.instr_gnt_o = w_gnt_instr;
    assign bus.data_gnt_o  = w_gnt_data;

    // A granted data write never touches the ROM; it is answered with an error.
    assign bus.rom_en_o   = w_gnt_instr | (w_gnt_data & ~bus.data_we_i);
    assign bus.rom_addr_o = w_gnt_instr ? bus.instr_addr_i :
                            w_gnt_data  ? bus.data_addr_i  : {ADDR_WIDTH{1'b0}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_owner  <= PORT_INSTR;
            r_last   <= PORT_DATA;
        end else begin
            r_rvalid <= w_any_gnt;
            if (w_any_gnt) begin
                r_owner <= w_winner;
                r_err   <= w_gnt_data & bus.data_we_i;
                r_last  <= w_winner;
            end
        end
    end

    assign w_instr_valid = r_rvalid && (r_owner == PORT_INSTR);
    assign w_data_valid  = r_rvalid && (r_owner == PORT_DATA);

    assign bus.instr_rvalid_o = w_instr_valid;
    assign bus.instr_rdata_o  = w_instr_valid ? bus.rom_rdata_i : {DATA_WIDTH{1'b0}};
    assign bus.data_rvalid_o  = w_data_valid;
    assign bus.data_rdata_o   = (w_data_valid && !r_err) ? bus.rom_rdata_i : {DATA_WIDTH{1'b0}};
    assign bus.data_err_o     = w_data_valid & r_err;
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Randomized + directed bench for boot_rom_arbiter; two instances (round-robin and fixed priority)
// are driven identically and compared against a transaction-level model with a ROM content function.
module tb_boot_rom_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    boot_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    boot_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    boot_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    boot_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] addr);
        logic [DW-1:0] idx;
        idx = DW'(addr >> 2);
        return 32'h5A00_0000 + idx * 32'h0001_0203;
    endfunction

    // ROM wrappers: one-cycle synchronous read
    always @(posedge clk) if (if0.rom_en_o) if0.rom_rdata_i <= rom_word(if0.rom_addr_o);
    always @(posedge clk) if (if1.rom_en_o) if1.rom_rdata_i <= rom_word(if1.rom_addr_o);

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model state per instance: index 0 = round-robin, 1 = fixed priority. Port 0 = instr, 1 = data.
    int            m_last     [2];
    bit            m_pend     [2];
    int            m_pend_port[2];
    bit            m_pend_err [2];
    logic [AW-1:0] m_pend_addr[2];

    logic          s_ireq, s_dreq, s_dwe;
    logic [AW-1:0] s_iaddr, s_daddr;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            m_pend[k] = 1'b0;
            m_pend_port[k] = 0;
            m_pend_err[k] = 1'b0;
            m_pend_addr[k] = '0;
        end
    endtask

    function automatic int pick_winner(input int k);
        if (s_ireq && s_dreq) return (k == 1) ? 0 : 1 - m_last[k];
        if (s_ireq) return 0;
        if (s_dreq) return 1;
        return -1;
    endfunction

    task automatic check_resp_one(input int k, input logic irv, input logic [DW-1:0] ird,
                                  input logic drv, input logic [DW-1:0] drd, input logic derr);
        bit is_i, is_d;
        string p;
        p = (k == 0) ? "rr" : "fp";
        is_i = m_pend[k] && m_pend_port[k] == 0;
        is_d = m_pend[k] && m_pend_port[k] == 1;
        check({p, ".instr_rvalid"}, DW'(irv), DW'(is_i));
        check({p, ".instr_rdata"}, ird, is_i ? rom_word(m_pend_addr[k]) : '0);
        check({p, ".data_rvalid"}, DW'(drv), DW'(is_d));
        check({p, ".data_rdata"}, drd, (is_d && !m_pend_err[k]) ? rom_word(m_pend_addr[k]) : '0);
        check({p, ".data_err"}, DW'(derr), DW'(is_d && m_pend_err[k]));
    endtask

    task automatic check_resp();
        check_resp_one(0, if0.instr_rvalid_o, if0.instr_rdata_o, if0.data_rvalid_o,
                       if0.data_rdata_o, if0.data_err_o);
        check_resp_one(1, if1.instr_rvalid_o, if1.instr_rdata_o, if1.data_rvalid_o,
                       if1.data_rdata_o, if1.data_err_o);
    endtask

    task automatic check_gnt_one(input int k, input logic gi, input logic gd,
                                 input logic en, input logic [AW-1:0] addr);
        int w;
        string p;
        p = (k == 0) ? "rr" : "fp";
        w = pick_winner(k);
        check({p, ".instr_gnt"}, DW'(gi), DW'(w == 0));
        check({p, ".data_gnt"}, DW'(gd), DW'(w == 1));
        check({p, ".rom_en"}, DW'(en), DW'(w == 0 || (w == 1 && !s_dwe)));
        check({p, ".rom_addr"}, DW'(addr), DW'((w == 0) ? s_iaddr : (w == 1) ? s_daddr : '0));
        m_pend[k] = (w >= 0);
        if (w >= 0) begin
            m_pend_port[k] = w;
            m_pend_err[k]  = (w == 1) && s_dwe;
            m_pend_addr[k] = (w == 0) ? s_iaddr : s_daddr;
            m_last[k]      = w;
        end
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic [AW-1:0] da, input logic we);
        s_ireq = ir; s_iaddr = ia; s_dreq = dr; s_daddr = da; s_dwe = we;
        if0.instr_req_i = ir; if0.instr_addr_i = ia; if0.data_req_i = dr;
        if0.data_addr_i = da; if0.data_we_i = we;
        if1.instr_req_i = ir; if1.instr_addr_i = ia; if1.data_req_i = dr;
        if1.data_addr_i = da; if1.data_we_i = we;
    endtask

    // One bus cycle: check last cycle's responses, apply new inputs, check the same-cycle grant.
    task automatic step(input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic [AW-1:0] da, input logic we);
        @(negedge clk);
        check_resp();
        drive(ir, ia, dr, da, we);
        #1;
        check_gnt_one(0, if0.instr_gnt_o, if0.data_gnt_o, if0.rom_en_o, if0.rom_addr_o);
        check_gnt_one(1, if1.instr_gnt_o, if1.data_gnt_o, if1.rom_en_o, if1.rom_addr_o);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rr_outs"}, DW'({if0.instr_gnt_o, if0.data_gnt_o, if0.instr_rvalid_o,
              if0.data_rvalid_o, if0.data_err_o, if0.rom_en_o}), '0);
        check({tag, ".fp_outs"}, DW'({if1.instr_gnt_o, if1.data_gnt_o, if1.instr_rvalid_o,
              if1.data_rvalid_o, if1.data_err_o, if1.rom_en_o}), '0);
        check({tag, ".rdata"}, if0.instr_rdata_o | if0.data_rdata_o |
              if1.instr_rdata_o | if1.data_rdata_o, '0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        if0.rom_rdata_i = '0;
        if1.rom_rdata_i = '0;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single fetch of word 2
        step(1'b1, 16'h0008, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        // Both requesting for 4 cycles: rr alternates, fp always instr
        repeat (4) step(1'b1, 16'h0000, 1'b1, 16'h0010, 1'b0);
        // Instr drops: fp finally serves data
        step(1'b0, '0, 1'b1, 16'h0010, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        // Data write gets an error response
        step(1'b0, '0, 1'b1, 16'h0004, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        // Back-to-back instruction stream
        for (int i = 0; i < 4; i++) step(1'b1, AW'(4 * i), 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);

        // Reset during an outstanding fetch drops its response
        step(1'b1, 16'h000C, 1'b0, '0, 1'b0);
        #1 rst_n = 1'b0;
        model_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 16'h0008, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'b0 + ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 255)),
                 1'b0 + ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 255)),
                 1'b0 + ($urandom_range(0, 4) == 0));
        end
        step(1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
Shares the single-ported boot ROM between the core instruction-fetch port and the core data port.
- Each port uses a req/gnt/rvalid handshake.
- The ROM has a 1-cycle synchronous read latency, so every granted read returns rvalid exactly one cycle later.
- Data-side writes are rejected with an error response.
- Sits between the core's instr/data interconnect and the boot ROM wrapper (en/addr/rdata).

Parameters:
ADDR_WIDTH, `ROM_ADDR_WIDTH, byte-address width presented to the ROM wrapper.
DATA_WIDTH, 32, read data width.
ARB_MODE, 0, 0 = round-robin between ports, 1 = fixed priority (instr always wins).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
instr_req_i  input  1  instruction fetch request
instr_addr_i  input  ADDR_WIDTH  instruction byte address
instr_gnt_o  output  1  instruction request accepted this cycle
instr_rvalid_o  output  1  instruction read data valid
instr_rdata_o  output  DATA_WIDTH  instruction read data
data_req_i  input  1  data request
data_addr_i  input  ADDR_WIDTH  data byte address
data_we_i  input  1  data write enable (illegal for ROM)
data_gnt_o  output  1  data request accepted this cycle
data_rvalid_o  output  1  data response valid
data_rdata_o  output  DATA_WIDTH  data read data
data_err_o  output  1  error flag, qualified by data_rvalid_o
rom_en_o  output  1  ROM read enable
rom_addr_o  output  ADDR_WIDTH  ROM byte address
rom_rdata_i  input  DATA_WIDTH  ROM read data, valid 1 cycle after rom_en_o

Behaviour:
Reset (asynchronous, rst_n=0):
- rvalid_r and err_r clear; owner_r = INSTR; last_r = DATA, so instr wins the first tie.
- All gnt/rvalid/err outputs are 0; rdata outputs are 0.

Grant (combinational, same cycle as req):
- Only one request is granted per cycle.
- Single requester: it is granted.
- Both requesting, ARB_MODE=0: grant the port that is not last_r.
- Both requesting, ARB_MODE=1: grant instr; data waits.
- last_r is updated to the granted port on every grant and holds when nothing is granted.
- gnt is never asserted without the matching req.

ROM drive:
- rom_en_o = 1 only when a read is granted (instr grant, or data grant with data_we_i=0).
- rom_addr_o = the winner's address, passed through unmodified; the wrapper drops bits [1:0].
- When idle, rom_addr_o = 0 and rom_en_o = 0.
- A data write grant does not assert rom_en_o.

Response pipeline (1 stage):
- On a grant, the next cycle sets rvalid_r=1, owner_r=winner, and err_r = (winner==DATA && data_we_i).
- Without a grant, rvalid_r=0 next cycle.
- instr_rvalid_o = rvalid_r && owner_r==INSTR; instr_rdata_o = rom_rdata_i when valid, else 0.
- data_rvalid_o = rvalid_r && owner_r==DATA.
- data_rdata_o = rom_rdata_i when valid and !err_r, else 0.
- data_err_o = err_r when valid, else 0.
- Back-to-back grants are allowed. A response and a new grant may occur in the same cycle, giving full throughput of 1 access/cycle.
- The outstanding response is always delivered regardless of req changes in the response cycle.

Boundary conditions:
- A requester dropping req without gnt is legal; nothing is issued.
- Under round-robin, simultaneous continuous requests alternate every cycle (I,D,I,D...).
- Under fixed priority, data is starved while instr_req_i is held.
- Reset asserted mid-transaction discards the pending response; no rvalid appears after reset release until a new grant.
- Addresses beyond the ROM depth are not checked; the ROM wrapper defines the returned data.

Test Plan:
1. Reset release, instr_req=1, addr=0x08 for one cycle -> instr_gnt=1 and rom_en=1, rom_addr=0x08 same cycle; next cycle instr_rvalid=1, instr_rdata=ROM word 2; data_rvalid stays 0.
2. ARB_MODE=0, both req held 4 cycles (instr 0x00, data 0x10) -> grants I,D,I,D; rvalids follow 1 cycle later on the matching port with words 0 and 4.
3. ARB_MODE=1, both req held 3 cycles -> instr_gnt=1 each cycle, data_gnt=0; drop instr_req -> data_gnt=1 next cycle, data_rvalid after 1 more cycle.
4. data_req=1, data_we=1, addr=0x04 -> data_gnt=1, rom_en=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
5. Grant instr read, assert rst_n=0 the following cycle before rvalid samples -> instr_rvalid=0 during and after reset; first post-reset request behaves as in scenario 1.
6. Continuous instr stream 0x00,0x04,0x08,0x0C -> 4 grants in 4 consecutive cycles, 4 rvalids in the next 4 cycles with in-order words 0..3.
